// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl - load/store controller between the execute stage and a word-only
// data memory.
//
// It accepts one byte, halfword or word load/store at a time and turns it into
// word-aligned memory accesses. Sub-word stores use read-modify-write. Loads
// return sign- or zero-extended data together with a one-cycle done pulse.
//
// Build option:
//   LSU_ALIGN_CHECK_EN
//     Defined: misaligned halfword and word requests complete with err=1.
//     Undefined: the offending low address bits are ignored.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high reset
//   req      in   request valid, sampled only while ready=1
//   wr       in   1 = store, 0 = load
//   funct3   in   [2:0] RISC-V size code
//   addr     in   [31:0] byte address
//   wdata    in   [31:0] store data
//   ready    out  idle, can accept a request
//   done     out  one-cycle completion pulse
//   rdata    out  [31:0] load result, valid with done
//   err      out  illegal or misaligned request, valid with done
//   mem_we   out  memory write enable
//   mem_a    out  [31:0] word-aligned memory address
//   mem_wd   out  [31:0] memory write data
//   mem_rd   in   [31:0] memory read data, combinational from mem_a
// -----------------------------------------------------------------------------
module lsu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_r;
  logic        wr_r;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic [31:0] wdata_r;

  logic        legal_s;
  logic        misalign_s;
  logic        bad_s;

  // Returns 1 when the size code is legal for the given direction.
  function automatic logic req_legal(input logic w, input logic [2:0] f);
    logic ok;
    ok = 1'b0;
    if (w) begin
      case (f)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end else begin
      case (f)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Selects the addressed lane of a memory word and extends it to 32 bits.
  // Halfword lane selection uses only off[1], so a misaligned halfword falls
  // back to its enclosing aligned lane when the alignment check is off.
  function automatic logic [31:0] load_extract(input logic [2:0]  f,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replaces the addressed byte/halfword lane of the old word with store data.
  function automatic logic [31:0] merge_lane(input logic [2:0]  f,
                                             input logic [1:0]  off,
                                             input logic [31:0] old,
                                             input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (f[1:0])
      2'b00: begin
        case (off)
          2'b00:   r[7:0]   = d[7:0];
          2'b01:   r[15:8]  = d[7:0];
          2'b10:   r[23:16] = d[7:0];
          2'b11:   r[31:24] = d[7:0];
          default: r = old;
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          r[31:16] = d[15:0];
        end else begin
          r[15:0] = d[15:0];
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Classifies the incoming request as legal / misaligned.
  always_comb begin
    legal_s    = req_legal(wr, funct3);
`ifdef LSU_ALIGN_CHECK_EN
    case (funct3[1:0])
      2'b01:   misalign_s = addr[0];
      2'b10:   misalign_s = (addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
`else
    misalign_s = 1'b0;
`endif
    bad_s      = !legal_s || misalign_s;
  end

  // Controller FSM; every output is a register so reset clears it at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      wr_r      <= 1'b0;
      funct3_r  <= 3'b000;
      addr_lo_r <= 2'b00;
      wdata_r   <= 32'h0000_0000;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0000_0000;
      mem_we    <= 1'b0;
      mem_a     <= 32'h0000_0000;
      mem_wd    <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          done   <= 1'b0;
          err    <= 1'b0;
          rdata  <= 32'h0000_0000;
          mem_we <= 1'b0;
          mem_wd <= 32'h0000_0000;
          if (req) begin
            wr_r      <= wr;
            funct3_r  <= funct3;
            addr_lo_r <= addr[1:0];
            wdata_r   <= wdata;
            mem_a     <= {addr[31:2], 2'b00};
            ready     <= 1'b0;
            if (bad_s) begin
              // Errors skip memory entirely and respond next cycle.
              state_r <= RESP;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              state_r <= ACCESS;
              // A word store needs no read, so it writes during ACCESS.
              if (wr && (funct3[1:0] == 2'b10)) begin
                mem_we <= 1'b1;
                mem_wd <= wdata;
              end else begin
                mem_we <= 1'b0;
                mem_wd <= 32'h0000_0000;
              end
            end
          end else begin
            ready <= 1'b1;
          end
        end

        ACCESS: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (!wr_r) begin
            rdata   <= load_extract(funct3_r, addr_lo_r, mem_rd);
            done    <= 1'b1;
            mem_we  <= 1'b0;
            mem_wd  <= 32'h0000_0000;
            state_r <= RESP;
          end else if (funct3_r[1:0] == 2'b10) begin
            rdata   <= 32'h0000_0000;
            done    <= 1'b1;
            mem_we  <= 1'b0;
            mem_wd  <= 32'h0000_0000;
            state_r <= RESP;
          end else begin
            // Sub-word store: old word is on mem_rd now, write merged word next.
            rdata   <= 32'h0000_0000;
            done    <= 1'b0;
            mem_we  <= 1'b1;
            mem_wd  <= merge_lane(funct3_r, addr_lo_r, mem_rd, wdata_r);
            state_r <= MERGE;
          end
        end

        MERGE: begin
          ready   <= 1'b0;
          err     <= 1'b0;
          rdata   <= 32'h0000_0000;
          done    <= 1'b1;
          mem_we  <= 1'b0;
          mem_wd  <= 32'h0000_0000;
          state_r <= RESP;
        end

        RESP: begin
          ready   <= 1'b1;
          done    <= 1'b0;
          err     <= 1'b0;
          rdata   <= 32'h0000_0000;
          mem_we  <= 1'b0;
          mem_wd  <= 32'h0000_0000;
          state_r <= IDLE;
        end

        default: begin
          ready   <= 1'b1;
          done    <= 1'b0;
          err     <= 1'b0;
          rdata   <= 32'h0000_0000;
          mem_we  <= 1'b0;
          mem_wd  <= 32'h0000_0000;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl - self-checking bench for lsu_ctrl.
// A 64-word memory sits on the memory port. A reference memory image and
// arithmetic load/store rules predict every response.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem     [0:63] = '{default: 32'h0};
  logic [31:0] ref_mem [0:63] = '{default: 32'h0};

  int compared   = 0;
  int mismatched = 0;

  lsu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wr     (wr),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .done   (done),
    .rdata  (rdata),
    .err    (err),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction. Called at a negedge with the DUT idle.
  task automatic do_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
    bit          legal, misal, exp_err;
    int          size, nbytes, shift, idx, exp_lat, exp_writes, lat, writes;
    logic [31:0] mask, word, val, exp_rdata;

    // Reference model.
    legal = w ? (f <= 3'd2) : (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
    size  = int'(f[1:0]);
    misal = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    if (size == 1 && (a % 2) != 0) misal = 1'b1;
    if (size == 2 && (a % 4) != 0) misal = 1'b1;
`endif
    exp_err    = !legal || misal;
    idx        = int'(a[7:2]);
    nbytes     = (size == 2) ? 4 : ((size == 1) ? 2 : 1);
    shift      = (size == 0) ? 8 * int'(a % 4) : ((size == 1) ? 16 * int'((a % 4) / 2) : 0);
    mask       = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    exp_rdata  = 32'h0;
    exp_writes = 0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat = 2;
      word    = ref_mem[idx];
      val     = (word >> shift) & mask;
      if (f[2] == 1'b0 && nbytes < 4 && ((val >> (8 * nbytes - 1)) & 32'd1) == 32'd1)
        val = val | ~mask;
      exp_rdata = val;
    end else begin
      exp_lat      = (nbytes == 4) ? 2 : 3;
      exp_writes   = 1;
      ref_mem[idx] = (ref_mem[idx] & ~(mask << shift)) | ((d & mask) << shift);
    end

    req = 1'b1; wr = w; funct3 = f; addr = a; wdata = d;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    lat    = 0;
    writes = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        writes++;
        check("mem_a_on_write", mem_a, {a[31:2], 2'b00});
      end
    end while (!done && lat < 8);
    check("latency", lat, exp_lat);
    check("err", {31'h0, err}, {31'h0, exp_err});
    check("rdata", rdata, exp_rdata);
    check("ready_busy", {31'h0, ready}, 32'h0);
    req = 1'b0;
    @(negedge clk);
    check("done_pulse", {31'h0, done}, 32'h0);
    check("ready_idle", {31'h0, ready}, 32'h1);
    check("write_count", writes, exp_writes);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    @(negedge clk);
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Word store then load.
    do_op(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0);
    do_op(1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
    // Sub-word read-modify-write.
    do_op(1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0);
    do_op(1'b1, 3'b000, 32'h13, 32'h000000AA, 1'b0);
    check("sb_merge", mem[4], 32'hAA223344);
    do_op(1'b1, 3'b001, 32'h10, 32'h00005566, 1'b0);
    check("sh_merge", mem[4], 32'hAA225566);
    // Sign / zero extension.
    do_op(1'b1, 3'b010, 32'h20, 32'h80FF7F01, 1'b0);
    do_op(1'b0, 3'b000, 32'h20, 32'h0, 1'b0);
    do_op(1'b0, 3'b000, 32'h22, 32'h0, 1'b0);
    do_op(1'b0, 3'b100, 32'h23, 32'h0, 1'b0);
    do_op(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
    do_op(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
    // Misaligned word load (error or lane-0 fallback depending on build).
    do_op(1'b1, 3'b010, 32'h04, 32'hCAFEF00D, 1'b0);
    do_op(1'b0, 3'b010, 32'h06, 32'h0, 1'b0);
    // Illegal size codes, then a store with req held high throughout.
    do_op(1'b0, 3'b011, 32'h0C, 32'h0, 1'b0);
    do_op(1'b1, 3'b100, 32'h0C, 32'h12345678, 1'b0);
    do_op(1'b1, 3'b010, 32'h18, 32'h0BADF00D, 1'b1);

    // Reset during the MERGE cycle of a byte store.
    do_op(1'b1, 3'b010, 32'h30, 32'h01020304, 1'b0);
    req = 1'b1; wr = 1'b1; funct3 = 3'b000; addr = 32'h31; wdata = 32'h000000EE;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("merge_we", {31'h0, mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_drops_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    check("rst_no_done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_word_kept", mem[12], 32'h01020304);
    check("rst_ready_after", {31'h0, ready}, 32'h1);
    check("rst_no_done2", {31'h0, done}, 32'h0);

    // Randomized traffic over the whole 256-byte window.
    for (int i = 0; i < 200; i++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
